// File: rtl/multi_channel_counter.sv
// Bank of independent up/down counters. Each channel has its own terminal compare and its own auto-reload.
// A single shared configuration port loads a channel whenever that channel is not running.
module multi_channel_counter #(
    parameter int WIDTH  = 64,
    parameter int NUM_CH = 4,
    parameter int START  = 10,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [WIDTH-1:0]        cfg_start,
    input  logic [WIDTH-1:0]        cfg_stop,
    input  logic                    cfg_down,
    input  logic                    cfg_wrap,
    input  logic [NUM_CH-1:0]       run_en,
    input  logic [NUM_CH-1:0]       clear,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       done_pulse
);

    // state | meaning
    // IDLE  | not counting; accepts configuration
    // RUN   | counting while run_en is set; terminal compare active
    // DONE  | one-shot reached stop; count held; accepts configuration
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

    state_t           r_state     [NUM_CH];
    state_t           w_state_nxt [NUM_CH];
    logic [WIDTH-1:0] r_count     [NUM_CH];
    logic [WIDTH-1:0] w_count_nxt [NUM_CH];
    logic [WIDTH-1:0] r_stop      [NUM_CH];
    logic [WIDTH-1:0] w_stop_nxt  [NUM_CH];
    logic [WIDTH-1:0] r_start     [NUM_CH];
    logic [WIDTH-1:0] w_start_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_down, w_down_nxt;
    logic [NUM_CH-1:0] r_wrap, w_wrap_nxt;
    logic [NUM_CH-1:0] r_pulse, w_pulse_nxt;
    logic [NUM_CH-1:0] w_accept;
    logic              w_ch_in_range;
    logic              w_sel_free;

    // The extra leading bit keeps the compare correct when NUM_CH is a power of two.
    assign w_ch_in_range = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

    always_comb begin
        w_sel_free = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_sel_free = (r_state[i] != ST_RUN);
            end
        end
    end

    assign cfg_ready = w_ch_in_range & w_sel_free;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_accept[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_count_nxt[i] = r_count[i];
            w_stop_nxt[i]  = r_stop[i];
            w_start_nxt[i] = r_start[i];
        end
        w_down_nxt  = r_down;
        w_wrap_nxt  = r_wrap;
        w_pulse_nxt = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            // A load beats a clear on the same edge.
            if (w_accept[i]) begin
                w_state_nxt[i] = ST_RUN;
                w_count_nxt[i] = cfg_start;
                w_start_nxt[i] = cfg_start;
                w_stop_nxt[i]  = cfg_stop;
                w_down_nxt[i]  = cfg_down;
                w_wrap_nxt[i]  = cfg_wrap;
            end else begin
                case (r_state[i])
                    ST_RUN: begin
                        if (clear[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else if (run_en[i]) begin
                            if (r_count[i] == r_stop[i]) begin
                                w_pulse_nxt[i] = 1'b1;
                                if (r_wrap[i]) begin
                                    w_count_nxt[i] = r_start[i];
                                end else begin
                                    w_state_nxt[i] = ST_DONE;
                                end
                            end else if (r_down[i]) begin
                                w_count_nxt[i] = r_count[i] - 1'b1;
                            end else begin
                                w_count_nxt[i] = r_count[i] + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (clear[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_count[i] <= START_V;
                r_stop[i]  <= START_V;
                r_start[i] <= START_V;
            end
            r_down  <= '0;
            r_wrap  <= '0;
            r_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_count[i] <= w_count_nxt[i];
                r_stop[i]  <= w_stop_nxt[i];
                r_start[i] <= w_start_nxt[i];
            end
            r_down  <= w_down_nxt;
            r_wrap  <= w_wrap_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign count[g*WIDTH +: WIDTH] = r_count[g];
        assign busy[g]                 = (r_state[g] == ST_RUN);
        assign done[g]                 = (r_state[g] == ST_DONE);
    end

    assign done_pulse = r_pulse;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed and random stimulus for multi_channel_counter (WIDTH=8, NUM_CH=5).
// Expected values come from a per-channel reference model.
module tb_multi_channel_counter;

    localparam int W   = 8;
    localparam int NCH = 5;
    localparam int CW  = 3;
    localparam int MOD = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   cfg_ch;
    logic [W-1:0]    cfg_start;
    logic [W-1:0]    cfg_stop;
    logic            cfg_down;
    logic            cfg_wrap;
    logic [NCH-1:0]  run_en;
    logic [NCH-1:0]  clear;
    logic [NCH*W-1:0] count;
    logic [NCH-1:0]  busy;
    logic [NCH-1:0]  done;
    logic [NCH-1:0]  done_pulse;

    int checks = 0;
    int errors = 0;

    // Model phase encoding: 0 idle, 1 running, 2 finished.
    int m_phase [NCH];
    int m_cnt   [NCH];
    int m_stop  [NCH];
    int m_start [NCH];
    bit m_down  [NCH];
    bit m_wrap  [NCH];
    bit m_pulse [NCH];

    multi_channel_counter #(.WIDTH(W), .NUM_CH(NCH), .START(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_down   (cfg_down),
        .cfg_wrap   (cfg_wrap),
        .run_en     (run_en),
        .clear      (clear),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NCH) return 1'b0;
        return m_phase[cfg_ch] != 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;
            m_cnt[c]   = 10;
            m_stop[c]  = 10;
            m_start[c] = 10;
            m_down[c]  = 1'b0;
            m_wrap[c]  = 1'b0;
            m_pulse[c] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count[%0d]", c), 64'(count[c*W +: W]), 64'(m_cnt[c]));
            chk($sformatf("busy[%0d]", c), 64'(busy[c]), 64'(m_phase[c] == 1));
            chk($sformatf("done[%0d]", c), 64'(done[c]), 64'(m_phase[c] == 2));
            chk($sformatf("done_pulse[%0d]", c), 64'(done_pulse[c]), 64'(m_pulse[c]));
        end
    endtask

    // Called just after an active edge with new inputs applied; advances one clock.
    task automatic cyc();
        bit rdy;
        #1;
        rdy = model_ready();
        chk("cfg_ready", 64'(cfg_ready), 64'(rdy));
        for (int c = 0; c < NCH; c++) begin
            m_pulse[c] = 1'b0;
            if (cfg_valid && rdy && int'(cfg_ch) == c) begin
                m_phase[c] = 1;
                m_cnt[c]   = int'(cfg_start);
                m_start[c] = int'(cfg_start);
                m_stop[c]  = int'(cfg_stop);
                m_down[c]  = cfg_down;
                m_wrap[c]  = cfg_wrap;
            end else if (m_phase[c] != 0 && clear[c]) begin
                m_phase[c] = 0;
            end else if (m_phase[c] == 1 && run_en[c]) begin
                if (m_cnt[c] == m_stop[c]) begin
                    m_pulse[c] = 1'b1;
                    if (m_wrap[c]) m_cnt[c] = m_start[c];
                    else           m_phase[c] = 2;
                end else begin
                    m_cnt[c] = (m_cnt[c] + (m_down[c] ? MOD - 1 : 1)) % MOD;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cfg_valid = 1'b0;
        run_en    = '0;
        clear     = '0;
        reset     = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all();
    endtask

    task automatic load(input int ch, input int st, input int sp, input bit dn, input bit wr);
        cfg_valid = 1'b1;
        cfg_ch    = CW'(ch);
        cfg_start = W'(st);
        cfg_stop  = W'(sp);
        cfg_down  = dn;
        cfg_wrap  = wr;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_down  = 1'b0;
        cfg_wrap  = 1'b0;
        run_en    = '0;
        clear     = '0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();

        // Channel 0: up one-shot 10..13
        load(0, 10, 13, 1'b0, 1'b0);
        run_en = 5'b00001;
        repeat (6) cyc();
        chk("ch0_final_count", 64'(count[0 +: W]), 64'd13);
        cfg_ch = 3'd0;
        cyc();

        // Channel 1: down wrap 1 -> 254 crossing zero
        load(1, 1, 254, 1'b1, 1'b1);
        run_en = 5'b00011;
        repeat (12) cyc();

        // Channel 2: gated enable, config attempt while running must be refused
        load(2, 0, 3, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            run_en[2] = (k % 2 == 0);
            if (k == 3) begin
                cfg_valid = 1'b1;
                cfg_ch    = 3'd2;
                cfg_start = 8'd99;
                cfg_stop  = 8'd120;
            end else begin
                cfg_valid = 1'b0;
            end
            cyc();
        end
        cfg_valid = 1'b0;

        // Channel 3: clear while running, then reset while running
        load(3, 20, 200, 1'b0, 1'b0);
        run_en = 5'b01000;
        repeat (3) cyc();
        clear = 5'b01000;
        cyc();
        clear = '0;
        repeat (2) cyc();
        clear = 5'b01000;
        cyc();
        clear = '0;
        load(3, 30, 200, 1'b0, 1'b0);
        repeat (3) cyc();
        do_reset();
        load(3, 40, 42, 1'b0, 1'b0);

        // Out-of-range channel numbers are never accepted
        cfg_valid = 1'b1;
        cfg_ch    = 3'd5;
        cyc();
        cfg_ch    = 3'd7;
        cyc();
        cfg_valid = 1'b0;

        // Channel 4: start == stop terminates at once; load beats clear on the same edge
        load(4, 5, 5, 1'b0, 1'b0);
        run_en = 5'b11000;
        repeat (2) cyc();
        clear = 5'b10000;
        load(4, 250, 3, 1'b0, 1'b1);
        clear = '0;
        repeat (12) cyc();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int d;
            if (n == 200) do_reset();
            d         = int'($urandom_range(0, 5));
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_ch    = CW'($urandom_range(0, 7));
            cfg_start = W'($urandom);
            cfg_down  = $urandom_range(0, 1) == 1;
            cfg_wrap  = $urandom_range(0, 1) == 1;
            cfg_stop  = cfg_down ? W'(int'(cfg_start) - d) : W'(int'(cfg_start) + d);
            run_en    = NCH'($urandom);
            for (int c = 0; c < NCH; c++) clear[c] = ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
